mem_word_master: RTL

//  CPU-side initiator for the byte-wide memory controller of the x8086 core.

---
 rtl/mem_word_master.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_word_master.sv
// Byte-wide memory initiator: one byte/word access per request (seg:off), little-endian byte cycles.
// Define MEM_SEGWRAP_EN to wrap the second byte's offset inside the segment (8086 style).
module mem_word_master #(
   parameter int CAS_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic        i_wide,
   input  logic        i_we,
   input  logic [15:0] i_seg,
   input  logic [15:0] i_off,
   input  logic [15:0] i_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic [15:0] o_rdata,
   output logic [19:0] o_mem_addr,
   output logic [7:0]  o_mem_data,
   output logic        o_mem_write,
   input  logic [7:0]  i_mem_data
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADR0 = 3'd1;
   localparam logic [2:0] S_ADR1 = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   // cnt_q is 1 in the A0 cycle; byte n of a read arrives when cnt_q == n+1+CAS_LAT
   localparam logic [2:0] LAST_LO = 3'(CAS_LAT + 1);
   localparam logic [2:0] LAST_HI = 3'(CAS_LAT + 2);

   logic [2:0]  state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] rdata_q, rdata_d;
   logic [19:0] addr_q, addr_d;
   logic [7:0]  mdata_q, mdata_d;
   logic        mwrite_q, mwrite_d;

   logic        wide_q, we_q;
   logic [7:0]  wdhi_q;
   logic [19:0] a1_q;
   logic [7:0]  lo_q;

   logic        accept;
   logic        rd_active;
   logic        cap_lo;
   logic [19:0] a0;
   logic [19:0] a1;
   logic [2:0]  last_cnt;

   assign o_busy      = (state_q == S_ADR0) || (state_q == S_ADR1) || (state_q == S_WAIT);
   assign o_done      = (state_q == S_DONE);
   assign o_rdata     = rdata_q;
   assign o_mem_addr  = addr_q;
   assign o_mem_data  = mdata_q;
   assign o_mem_write = mwrite_q;

   assign accept    = i_req && !o_busy;
   assign a0        = {i_seg, 4'h0} + {4'h0, i_off};
`ifdef MEM_SEGWRAP_EN
   logic [15:0] off_inc;
   assign off_inc   = i_off + 16'd1;
   assign a1        = {i_seg, 4'h0} + {4'h0, off_inc};
`else
   assign a1        = a0 + 20'd1;
`endif

   assign rd_active = o_busy && !we_q;
   assign cap_lo    = rd_active && (cnt_q == LAST_LO);
   assign last_cnt  = wide_q ? LAST_HI : LAST_LO;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      addr_d   = addr_q;
      mdata_d  = mdata_q;
      mwrite_d = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               state_d  = S_ADR0;
               cnt_d    = 3'd1;
               addr_d   = a0;
               mdata_d  = i_wdata[7:0];
               mwrite_d = i_we;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_ADR0: begin
            cnt_d = cnt_q + 3'd1;
            if (wide_q) begin
               state_d  = S_ADR1;
               addr_d   = a1_q;
               mdata_d  = wdhi_q;
               mwrite_d = we_q;
            end else begin
               state_d  = we_q ? S_DONE : S_WAIT;
            end
         end
         S_ADR1: begin
            cnt_d   = cnt_q + 3'd1;
            state_d = we_q ? S_DONE : S_WAIT;
         end
         S_WAIT: begin
            // The final byte is taken straight off the bus into the result
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == last_cnt) begin
               state_d = S_DONE;
               rdata_d = wide_q ? {i_mem_data, lo_q} : {8'h00, i_mem_data};
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 3'd0;
         rdata_q  <= 16'h0000;
         addr_q   <= 20'h00000;
         mdata_q  <= 8'h00;
         mwrite_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         addr_q   <= addr_d;
         mdata_q  <= mdata_d;
         mwrite_q <= mwrite_d;
      end
   end

   // Request snapshot and low read byte; only meaningful while a transfer is active
   always_ff @(posedge clk) begin
      if (accept && !o_busy) begin
         wide_q <= i_wide;
         we_q   <= i_we;
         wdhi_q <= i_wdata[15:8];
         a1_q   <= a1;
      end
      if (cap_lo) begin
         lo_q <= i_mem_data;
      end
   end

endmodule
